fsmv_req_arbiter: RTL and testbench
===================================

// Module: fsmv_req_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one fsm_vectors engine among NREQ requesters.
//  Grants one requester, drives ena/data_in to the engine, waits for intr, pulses ack,
//  returns data_out/specreg to the winner, then re-arbitrates. Sits between client
//  blocks and the fsm_vectors instance, in the same clock domain.
// PARAMETERS
//  NREQ    4    number of requesters (2..8)
//  IDW     2    requester-id width, >= clog2(NREQ)
//  DW      23   data width, matches fsm_vectors data_in/data_out
//  TMO     255  intr timeout in cycles (used only with FSMV_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1        system clock, rising edge
//  arst_n       in   1        synchronous, active-low reset
//  req          in   NREQ     request per client; level, sampled only in IDLE
//  req_data     in   NREQ*DW  client payloads, client i at [i*DW +: DW]
//  gnt          out  NREQ     one-hot, 1-cycle pulse; payload captured that cycle
//  busy         out  1        high in every state except IDLE
//  fsm_ena      out  1        to fsm_vectors.ena
//  fsm_data     out  DW       to fsm_vectors.data_in, stable while fsm_ena=1
//  fsm_ack      out  1        to fsm_vectors.ack, 1-cycle pulse
//  fsm_intr     in   1        from fsm_vectors.intr
//  fsm_specreg  in   4        from fsm_vectors.specreg
//  fsm_stop     in   1        from fsm_vectors.stop
//  fsm_dout     in   DW       from fsm_vectors.data_out
//  rsp_valid    out  1        1-cycle pulse: response fields valid
//  rsp_id       out  IDW      index of served requester
//  rsp_data     out  DW       captured fsm_dout (0 on error)
//  rsp_spec     out  4        captured fsm_specreg (0 on error)
//  rsp_err      out  1        1 = aborted by fsm_stop or timeout
// BEHAVIOUR
//  Reset (arst_n=0 at a clk edge): state=IDLE; all outputs 0; rr pointer = NREQ-1.
//   Client 0 therefore has highest priority first. Reset mid-transaction aborts it.
//   No rsp_valid is produced for the aborted transaction.
//  FSM: IDLE -> ISSUE -> WAIT -> ACK -> RESP -> IDLE. Every transition is registered.
//  IDLE: if |req, pick first set bit searching from ptr+1 with wrap-around.
//   Latch id and payload, set gnt bit, go ISSUE. If req==0, stay IDLE.
//  ISSUE (1 cycle): gnt high, fsm_ena=1, fsm_data=latched payload; go WAIT.
//  WAIT: fsm_ena=1 held. fsm_intr=1 -> capture fsm_dout/fsm_specreg, err=0, go ACK.
//   fsm_stop=1 with fsm_intr=0 -> err=1, go ACK. intr and stop together: intr wins.
//  ACK (1 cycle): fsm_ack=1, fsm_ena=0; go RESP.
//  RESP (1 cycle): rsp_valid=1 with id/data/spec/err; ptr<=id; go IDLE.
//  Latency: gnt to fsm_ena = 0 cycles (same cycle). intr sampled to fsm_ack = 1 cycle.
//   intr sampled to rsp_valid = 2 cycles. Min back-to-back grant spacing = 5 cycles.
//  Requests arriving or dropping while busy are ignored until IDLE; no queueing.
//  Single requester repeating: served every 5 cycles. All NREQ active: strict rotation.
//  rsp_* fields hold their last values between pulses; only rsp_valid pulses.
// CONFIGURATION
//  FSMV_ARB_TIMEOUT_EN defined: 8-bit counter clears on WAIT entry, counts each WAIT cycle.
//   Reaching TMO with no intr/stop -> err=1, rsp_data/spec=0, go ACK (ack still pulsed).
//  Undefined: no counter; WAIT ends only on fsm_intr or fsm_stop.
// STRUCTURE
//  Package fsmv_pkg: DW=23, SPEC_W=4, state encoding localparams (IDLE..RESP).
//   Shared with fsm_vectors and its bench.
//  Sub-module fsmv_rr_pick: combinational round-robin picker.
//   Inputs req and ptr; outputs one-hot grant, index and any.
// TESTING
//  1 reset: arst_n=0 for 3 cycles mid-WAIT -> all outputs 0, IDLE.
//    Next req[2] served first with no stale rsp.
//  2 single: req=4'b0010, data1=23'd15535, model intr after 6 cycles, dout=55555, spec=4'hA
//    -> gnt=0010; rsp_id=1, rsp_data=55555, rsp_spec=A, err=0, rsp_valid 2 cycles after intr.
//  3 rotation: req=4'b1111 held 40 cycles -> grant order 0,1,2,3,0,...
//    Exactly 1 ack per grant, 5-cycle spacing.
//  4 stop/intr: stop alone in WAIT -> rsp_err=1, rsp_data=0.
//    stop+intr in the same cycle -> err=0, data captured.
//  5 timeout (macro on, TMO=10): intr never rises -> ack at WAIT+10, rsp_err=1.
//    Macro off: busy stays high.
//  6 late req: req[3] rises during WAIT of client 0 -> ignored until IDLE, then gnt=1000.

Source files
------------

// File: rtl/fsmv_pkg.sv
// Shared definitions for the fsm_vectors engine, its request arbiter and their benches.
package fsmv_pkg;

  localparam int unsigned DW     = 23;
  localparam int unsigned SPEC_W = 4;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] ACK   = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = IDLE,
    StIssue = ISSUE,
    StWait  = WAIT,
    StAck   = ACK,
    StResp  = RESP
  } state_e;

endpackage

// File: rtl/fsmv_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping around.
module fsmv_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic           hi_found, lo_found;
  logic [IDW-1:0] hi_idx, lo_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Descending scan so the lowest index in each half is the one left standing.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        if (i > int'(ptr_i)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDW'(i);
        end
      end
    end
    idx_o = hi_found ? hi_idx : lo_idx;
    any_o = hi_found | lo_found;
    gnt_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_o[i] = any_o && (IDW'(i) == idx_o);
    end
  end

endmodule

// File: rtl/fsmv_req_arbiter.sv
// Round-robin sequencer sharing one fsm_vectors engine among NREQ clients.
// Optional intr watchdog enabled by defining FSMV_ARB_TIMEOUT_EN.
module fsmv_req_arbiter
  import fsmv_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned DW   = fsmv_pkg::DW,
  parameter int unsigned TMO  = 255
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic               fsm_ena,
  output logic [DW-1:0]      fsm_data,
  output logic               fsm_ack,
  input  logic               fsm_intr,
  input  logic [SPEC_W-1:0]  fsm_specreg,
  input  logic               fsm_stop,
  input  logic [DW-1:0]      fsm_dout,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic [SPEC_W-1:0]  rsp_spec,
  output logic               rsp_err
);

  state_e              state_q;
  logic [IDW-1:0]      ptr_q, id_q;
  logic [DW-1:0]       cap_data_q;
  logic [SPEC_W-1:0]   cap_spec_q;
  logic                cap_err_q;

  logic [NREQ-1:0]     pick_gnt;
  logic [IDW-1:0]      pick_idx;
  logic                pick_any;
  logic [DW-1:0]       pick_data;

`ifdef FSMV_ARB_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TMO - 1);
  logic [7:0]          tmo_cnt_q;
`endif

  fsmv_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_data = req_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      ptr_q      <= IDW'(NREQ - 1);
      id_q       <= '0;
      cap_data_q <= '0;
      cap_spec_q <= '0;
      cap_err_q  <= 1'b0;
      gnt        <= '0;
      busy       <= 1'b0;
      fsm_ena    <= 1'b0;
      fsm_data   <= '0;
      fsm_ack    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_spec   <= '0;
      rsp_err    <= 1'b0;
`ifdef FSMV_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      gnt       <= '0;
      fsm_ack   <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            id_q     <= pick_idx;
            fsm_data <= pick_data;
            gnt      <= pick_gnt;
            fsm_ena  <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
`ifdef FSMV_ARB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        StWait: begin
          // intr has priority over stop when both arrive together.
          if (fsm_intr) begin
            cap_data_q <= fsm_dout;
            cap_spec_q <= fsm_specreg;
            cap_err_q  <= 1'b0;
            fsm_ena    <= 1'b0;
            fsm_ack    <= 1'b1;
            state_q    <= StAck;
          end else if (fsm_stop) begin
            cap_data_q <= '0;
            cap_spec_q <= '0;
            cap_err_q  <= 1'b1;
            fsm_ena    <= 1'b0;
            fsm_ack    <= 1'b1;
            state_q    <= StAck;
          end
`ifdef FSMV_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TmoLast) begin
            cap_data_q <= '0;
            cap_spec_q <= '0;
            cap_err_q  <= 1'b1;
            fsm_ena    <= 1'b0;
            fsm_ack    <= 1'b1;
            state_q    <= StAck;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end
        StAck: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_data  <= cap_data_q;
          rsp_spec  <= cap_spec_q;
          rsp_err   <= cap_err_q;
          ptr_q     <= id_q;
          state_q   <= StResp;
        end
        StResp: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fsmv_req_arbiter.sv
// Scoreboard bench for fsmv_req_arbiter with a small behavioural fsm_vectors engine.
module tb_fsmv_req_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = 23;
`ifdef FSMV_ARB_TIMEOUT_EN
  localparam int TMO  = 10;
`else
  localparam int TMO  = 255;
`endif

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   pay;
  } gnt_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [3:0]     spec;
    logic           err;
    bit             chk_lat;
  } rsp_t;

  logic               clk = 1'b0;
  logic               arst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               busy, fsm_ena, fsm_ack, fsm_intr, fsm_stop, rsp_valid, rsp_err;
  logic [DW-1:0]      fsm_data, fsm_dout, rsp_data;
  logic [3:0]         fsm_specreg, rsp_spec;
  logic [IDW-1:0]     rsp_id;

  logic [DW-1:0] pay [NREQ];
  int            eng_mode, eng_delay, ena_cnt, ev_cyc;
  logic [DW-1:0] eng_dout;
  logic [3:0]    eng_spec;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            ack_cnt = 0;
  int            last_gnt_cyc = 0;
  bit            chk_spacing = 0, have_prev = 0, tmo_chk = 0;
  gnt_t          gnt_q[$];
  rsp_t          rsp_q[$];
  gnt_t          g;
  rsp_t          r;

  assign req_data    = {pay[3], pay[2], pay[1], pay[0]};
  assign fsm_dout    = eng_dout;
  assign fsm_specreg = eng_spec;

  fsmv_req_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .DW   (DW),
    .TMO  (TMO)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .busy        (busy),
    .fsm_ena     (fsm_ena),
    .fsm_data    (fsm_data),
    .fsm_ack     (fsm_ack),
    .fsm_intr    (fsm_intr),
    .fsm_specreg (fsm_specreg),
    .fsm_stop    (fsm_stop),
    .fsm_dout    (fsm_dout),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_spec    (rsp_spec),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine model: fires intr/stop once, eng_delay cycles after fsm_ena rises (ISSUE = 1).
  always @(negedge clk) begin
    if (fsm_ena) ena_cnt = ena_cnt + 1;
    else ena_cnt = 0;
    fsm_intr = 1'b0;
    fsm_stop = 1'b0;
    if (fsm_ena && ena_cnt == eng_delay && eng_mode != 0) begin
      fsm_intr = (eng_mode == 1) || (eng_mode == 3);
      fsm_stop = (eng_mode == 2) || (eng_mode == 3);
      ev_cyc   = cyc;
    end
  end

  // Monitor: pops expected grants/responses whenever the DUT presents them.
  always @(negedge clk) begin
    if (fsm_ack) begin
      ack_cnt++;
      if (tmo_chk) check("tmo_ack_latency", 64'(cyc - last_gnt_cyc), 64'd11);
    end
    if (gnt != '0) begin
      if (gnt_q.size() == 0) begin
        check("gnt_unexpected", 64'(gnt), 64'd0);
      end else begin
        g = gnt_q.pop_front();
        check("gnt", 64'({gnt, fsm_ena, fsm_data}), 64'({g.gnt, 1'b1, g.pay}));
      end
      if (chk_spacing && have_prev) check("gnt_spacing", 64'(cyc - last_gnt_cyc), 64'd5);
      have_prev    = 1'b1;
      last_gnt_cyc = cyc;
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        r = rsp_q.pop_front();
        check("rsp", 64'({rsp_id, rsp_data, rsp_spec, rsp_err}),
              64'({r.id, r.data, r.spec, r.err}));
        if (r.chk_lat) check("rsp_latency", 64'(cyc - ev_cyc), 64'd2);
      end
    end
  end

  task automatic push_gnt(input logic [NREQ-1:0] gv, input logic [DW-1:0] p);
    gnt_q.push_back('{gnt: gv, pay: p});
  endtask

  task automatic push_rsp(input logic [IDW-1:0] id, input logic [DW-1:0] d,
                          input logic [3:0] s, input logic e, input bit lat);
    rsp_q.push_back('{id: id, data: d, spec: s, err: e, chk_lat: lat});
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < budget);
    if (gnt == '0) check("gnt_wait", 64'(|gnt), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, 64'({busy, gnt, fsm_ena, fsm_ack, rsp_valid}), 64'd0);
    check({name, "_rsp"}, 64'({rsp_id, rsp_data, rsp_spec, rsp_err}), 64'd0);
    check({name, "_data"}, 64'(fsm_data), 64'd0);
  endtask

  initial begin
    int n;
    arst_n    = 1'b0;
    req       = '0;
    eng_mode  = 0;
    eng_delay = 2;
    ena_cnt   = 0;
    ev_cyc    = 0;
    eng_dout  = '0;
    eng_spec  = '0;
    pay[0] = 23'h00AAA;
    pay[1] = 23'd15535;
    pay[2] = 23'h7ABCD;
    pay[3] = 23'h12345;

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_zero("reset");
    arst_n = 1'b1;

    // Reset mid-WAIT aborts client 1 with no response; client 2 served next.
    eng_mode = 0;
    push_gnt(4'b0010, pay[1]);
    req = 4'b0010;
    wait_gnt(20);
    req = '0;
    repeat (4) @(negedge clk);
    check("busy_in_wait", 64'(busy), 64'd1);
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("midwait_reset");
    arst_n    = 1'b1;
    eng_mode  = 1;
    eng_delay = 3;
    eng_dout  = 23'h0F0F0;
    eng_spec  = 4'h6;
    push_gnt(4'b0100, pay[2]);
    push_rsp(2'd2, 23'h0F0F0, 4'h6, 1'b0, 1'b1);
    req = 4'b0100;
    wait_gnt(20);
    req = '0;
    wait_idle(50);

    // Single requester.
    eng_delay = 6;
    eng_dout  = 23'd55555;
    eng_spec  = 4'hA;
    push_gnt(4'b0010, 23'd15535);
    push_rsp(2'd1, 23'd55555, 4'hA, 1'b0, 1'b1);
    req = 4'b0010;
    wait_gnt(20);
    req = '0;
    wait_idle(50);

    // All clients active from reset: strict rotation, 5-cycle spacing, one ack per grant.
    do_reset();
    eng_mode  = 1;
    eng_delay = 2;
    eng_dout  = 23'h01234;
    eng_spec  = 4'h3;
    for (int k = 0; k < 8; k++) begin
      push_gnt(4'b0001 << (k % 4), pay[k%4]);
      push_rsp(IDW'(k % 4), 23'h01234, 4'h3, 1'b0, 1'b1);
    end
    n = ack_cnt;
    have_prev   = 1'b0;
    chk_spacing = 1'b1;
    req = 4'b1111;
    begin
      int seen = 0;
      int t = 0;
      while (seen < 8 && t < 100) begin
        @(negedge clk);
        t++;
        if (gnt != '0) seen++;
      end
      req = '0;
      check("rot_grants", 64'(seen), 64'd8);
    end
    wait_idle(50);
    chk_spacing = 1'b0;
    check("rot_acks", 64'(ack_cnt - n), 64'd8);

    // stop alone, then stop together with intr.
    eng_mode  = 2;
    eng_delay = 3;
    eng_dout  = 23'h55AA5;
    eng_spec  = 4'hF;
    push_gnt(4'b0100, pay[2]);
    push_rsp(2'd2, 23'd0, 4'h0, 1'b1, 1'b1);
    req = 4'b0100;
    wait_gnt(20);
    req = '0;
    wait_idle(50);
    eng_mode = 3;
    push_gnt(4'b1000, pay[3]);
    push_rsp(2'd3, 23'h55AA5, 4'hF, 1'b0, 1'b1);
    req = 4'b1000;
    wait_gnt(20);
    req = '0;
    wait_idle(50);

`ifdef FSMV_ARB_TIMEOUT_EN
    // Engine silent: watchdog aborts after TMO WAIT cycles.
    eng_mode = 0;
    tmo_chk  = 1'b1;
    push_gnt(4'b0001, pay[0]);
    push_rsp(2'd0, 23'd0, 4'h0, 1'b1, 1'b0);
    req = 4'b0001;
    wait_gnt(20);
    req = '0;
    wait_idle(60);
    tmo_chk = 1'b0;
`else
    // No watchdog: WAIT holds until the engine finally stops.
    eng_mode  = 2;
    eng_delay = 300;
    push_gnt(4'b0001, pay[0]);
    push_rsp(2'd0, 23'd0, 4'h0, 1'b1, 1'b1);
    req = 4'b0001;
    wait_gnt(20);
    req = '0;
    repeat (200) @(negedge clk);
    check("busy_hold", 64'({busy, fsm_ena}), 64'b11);
    wait_idle(200);
`endif

    // Late request during WAIT is ignored until IDLE.
    eng_mode  = 1;
    eng_delay = 5;
    eng_dout  = 23'h3C3C3;
    eng_spec  = 4'h9;
    push_gnt(4'b0001, pay[0]);
    push_gnt(4'b1000, pay[3]);
    push_rsp(2'd0, 23'h3C3C3, 4'h9, 1'b0, 1'b1);
    push_rsp(2'd3, 23'h3C3C3, 4'h9, 1'b0, 1'b1);
    req = 4'b0001;
    wait_gnt(20);
    req = 4'b1000;
    repeat (2) @(negedge clk);
    check("late_req_ignored", 64'({busy, gnt}), 64'({1'b1, 4'b0000}));
    wait_gnt(30);
    req = '0;
    wait_idle(50);

    repeat (5) @(negedge clk);
    check("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
